bcd_scan_ctrl: RTL and testbench
================================

// Module: bcd_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a row of 14-segment digits. It sits
//   directly upstream of the BCD-to-14-segment decoder. Each cycle it presents
//   one BCD nibble on bcd_out to that decoder, and drives the matching
//   active-low digit enable. It snapshots the multi-digit input once per frame
//   so a frame never mixes old and new values. It also inserts anti-ghost
//   blanking between digits and can suppress leading zeros.
// PARAMETERS
//   NUM_DIGITS    4      digits scanned; legal range 1..8; index 0 = rightmost/LSD
//   REFRESH_DIV   50000  clk cycles per digit slot; must exceed BLANK_CYCLES
//   BLANK_CYCLES  16     cycles at the start of each slot with every digit off; 0 allowed
// PORTS
//   clk        in   1             system clock, rising edge
//   rst        in   1             synchronous, active-high reset
//   bcd_in     in   4*NUM_DIGITS  packed BCD digits; digit k = bcd_in[4k+3:4k]
//   blank_lz   in   1             1 = suppress leading zeros (digit 0 is never suppressed)
//   bcd_out    out  4             nibble to the decoder; 4'hF = blank (decoder outputs all-off)
//   digit_en   out  NUM_DIGITS    one-cold (active-low) digit select; all-1s = nothing lit
//   frame_start out 1             one-cycle pulse on the first output cycle of slot 0
// BEHAVIOUR
//   - All outputs are registered. Reset values: bcd_out=4'hF, digit_en=all 1s,
//     frame_start=0. Internal prescaler, slot index and shadow register all reset to 0.
//   - Output timeline:
//     - First output cycle of slot 0 is the cycle after the first clk edge with rst=0.
//     - Slot k lasts exactly REFRESH_DIV cycles.
//     - Slot index advances 0,1,..,NUM_DIGITS-1, then wraps to 0.
//     - Frame period = NUM_DIGITS*REFRESH_DIV cycles.
//   - Frame snapshot: the shadow register captures bcd_in on the edge that starts slot 0.
//     - frame_start is high exactly on that slot-0 first output cycle.
//     - Changes to bcd_in mid-frame take effect from the next frame only.
//   - Cycles 0..BLANK_CYCLES-1 of each slot: digit_en=all 1s, bcd_out=4'hF.
//   - Remaining cycles of slot k: digit_en bit k=0 (all others 1) and bcd_out=shadow digit k,
//     unless digit k is suppressed.
//   - A suppressed digit outputs digit_en=all 1s and bcd_out=4'hF for the whole slot.
//     Digit k is suppressed when either:
//     (a) its shadow nibble > 9 (invalid BCD); or
//     (b) blank_lz=1, k>0, and shadow digits k..NUM_DIGITS-1 are all 0.
//   - blank_lz is sampled continuously and is not snapshotted; it takes effect at the next slot boundary.
//   - rst asserted mid-slot or mid-frame: reset values appear on the next cycle.
//     After release, scanning restarts at slot 0 with a fresh snapshot and a frame_start pulse.
//   - Prescaler width = $clog2(REFRESH_DIV). Slot index width = $clog2(NUM_DIGITS), minimum 1.
//     No arithmetic overflow is permitted; both counters wrap by explicit compare.
// STRUCTURE
//   - Shared package entries:
//     - BCD_BLANK = 4'hF.
//     - BCD_MAX = 4'd9.
//     - Helper function is_valid_bcd(nibble).
//   - Sub-module scan_tick_gen (prescaler): outputs slot_end and in_blank strobes.
//   - Top level holds:
//     - slot index counter;
//     - shadow register;
//     - combinational leading-zero mask across NUM_DIGITS;
//     - output registers.
// TESTING (bench params NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//   1. rst=1 for 3 cycles -> bcd_out=F, digit_en=1111, frame_start=0 every cycle;
//      release -> frame_start=1 on the next cycle.
//   2. bcd_in=16'h1234, blank_lz=0 -> slot 0 cycles 2..7: digit_en=1110, bcd_out=4;
//      slot 1: 1101/3; slot 2: 1011/2; slot 3: 0111/1.
//      Next frame_start exactly 32 cycles after the previous one.
//   3. blank_lz=1, bcd_in=16'h0050 -> slots 3 and 2 dark (digit_en=1111, bcd_out=F);
//      slot 1 shows 5; slot 0 shows 0.
//      bcd_in=16'h0000 -> only slot 0 lit, showing 0.
//   4. bcd_in=16'h1234, switched to 16'h5678 during slot 1 -> slots 2 and 3 still show 2 and 1;
//      the next frame shows 8,7,6,5.
//   5. bcd_in=16'h12A4 -> slot 1 dark for all 8 cycles; the other slots show 4, 2 and 1.
//   6. rst pulsed for 1 cycle at cycle 3 of slot 2 -> next cycle shows reset values;
//      scan then restarts at slot 0 with frame_start=1 and a newly captured bcd_in.

Source files
------------

// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared constants and helpers for the BCD digit scan controller.
package bcd_scan_ctrl_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic is_valid_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_scan_tick_gen.sv
// Per-slot prescaler: strobes the first and last cycle of each digit slot
// and flags the anti-ghost blanking window at the start of the slot.
module scan_tick_gen #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_start,
  output logic slot_end,
  output logic in_blank
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

  // pre_cnt is the in-slot position of the output cycle produced at the next edge
  logic [PW-1:0] pre_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == LAST_CNT) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign slot_start = (pre_cnt == '0);
  assign slot_end   = (pre_cnt == LAST_CNT);

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pre_cnt < PW'(BLANK_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller feeding a BCD-to-14-segment decoder, with
// per-frame input snapshot, inter-digit blanking and leading-zero suppression.
module bcd_scan_ctrl
  import bcd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_DIGITS - 1);

  logic                    slot_start, slot_end, in_blank;
  logic [SW-1:0]           slot;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    sup_hold;
  logic                    frame_edge;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    zrun;
  logic [3:0]              cur_dig;
  logic                    cur_sup;
  logic                    eff_sup;

  logic [3:0]              bcd_p1;
  logic [NUM_DIGITS-1:0]   en_p1;
  logic                    fs_p1;

  scan_tick_gen #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .in_blank   (in_blank)
  );

  assign frame_edge = slot_start && (slot == '0);

  // On the frame edge the shadow is loaded this same edge, so read bcd_in directly
  always_comb begin
    snap    = frame_edge ? bcd_in : shadow;
    zrun    = 1'b1;
    sup     = '0;
    cur_dig = BCD_BLANK;
    cur_sup = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun   = zrun && (snap[4*k +: 4] == 4'd0);
      sup[k] = !is_valid_bcd(snap[4*k +: 4]) || (blank_lz && (k > 0) && zrun);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (SW'(k) == slot) begin
        cur_dig = snap[4*k +: 4];
        cur_sup = sup[k];
      end
    end
    eff_sup = slot_start ? cur_sup : sup_hold;
  end

  // Stage p1: registered decoder nibble, digit enables and frame marker
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      shadow   <= '0;
      sup_hold <= 1'b0;
      bcd_p1   <= BCD_BLANK;
      en_p1    <= '1;
      fs_p1    <= 1'b0;
    end else begin
      if (frame_edge) shadow <= bcd_in;
      if (slot_start) sup_hold <= cur_sup;
      if (slot_end) slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      fs_p1 <= frame_edge;
      if (in_blank || eff_sup) begin
        bcd_p1 <= BCD_BLANK;
        en_p1  <= '1;
      end else begin
        bcd_p1 <= cur_dig;
        en_p1  <= ~(NUM_DIGITS'(1) << slot);
      end
    end
  end

  assign bcd_out     = bcd_p1;
  assign digit_en    = en_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed plus randomized bench for bcd_scan_ctrl against a position-based reference model.
module tb_bcd_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = N * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bcd_in;
  logic          blank_lz;
  logic [3:0]    bcd_out;
  logic [N-1:0]  digit_en;
  logic          frame_start;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: position of the next output cycle since the scan restarted
  int          pos = 0;
  logic [15:0] snap_m = '0;
  logic        lz_m = 1'b0;

  bcd_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .blank_lz    (blank_lz),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic [3:0]  exp_bcd;
    logic [N-1:0] exp_en;
    logic        exp_fs;
    logic [15:0] hi;
    logic        sup;
    int          k, c;
    if (rst) begin
      exp_bcd = 4'hF;
      exp_en  = '1;
      exp_fs  = 1'b0;
      pos     = 0;
    end else begin
      if (pos % F == 0) snap_m = bcd_in;
      if (pos % R == 0) lz_m = blank_lz;
      k   = (pos / R) % N;
      c   = pos % R;
      hi  = snap_m >> (4 * k);
      sup = (hi[3:0] > 4'd9) || (lz_m && (k > 0) && (hi == 16'h0000));
      exp_fs = (pos % F == 0);
      if (c < B || sup) begin
        exp_bcd = 4'hF;
        exp_en  = '1;
      end else begin
        exp_bcd = hi[3:0];
        exp_en  = ~(N'(1) << k);
      end
      pos++;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (bcd_out === exp_bcd) else begin
      miscompares++;
      $error("FAIL bcd_out pos=%0d observed=%h expected=%h", pos, bcd_out, exp_bcd);
    end
    assert (digit_en === exp_en) else begin
      miscompares++;
      $error("FAIL digit_en pos=%0d observed=%b expected=%b", pos, digit_en, exp_en);
    end
    assert (frame_start === exp_fs) else begin
      miscompares++;
      $error("FAIL frame_start pos=%0d observed=%b expected=%b", pos, frame_start, exp_fs);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next output cycle sits at frame offset tgt; bounded
  task automatic to_pos(input int tgt);
    int guard;
    guard = 0;
    while ((pos % F) != tgt && guard < 2 * F) begin
      step();
      guard++;
    end
    assert (guard < 2 * F) else begin
      miscompares++;
      $error("FAIL to_pos timeout observed=%0d expected=%0d", pos % F, tgt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bcd_in   = 16'h1234;
    blank_lz = 1'b0;

    // 1. reset held, then release
    run(3);
    rst = 1'b0;

    // 2. plain scan over two frames
    run(2 * F);

    // 3. leading-zero blanking
    blank_lz = 1'b1;
    bcd_in   = 16'h0050;
    to_pos(0);
    run(F);
    bcd_in = 16'h0000;
    run(F);

    // 4. mid-frame input change
    blank_lz = 1'b0;
    bcd_in   = 16'h1234;
    to_pos(0);
    run(R + 3);
    bcd_in = 16'h5678;
    run(2 * F);

    // 5. invalid BCD digit
    bcd_in = 16'h12A4;
    to_pos(0);
    run(F);

    // 6. one-cycle reset at cycle 3 of slot 2
    bcd_in = 16'h9081;
    to_pos(2 * R + 3);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    bcd_in = 16'h4321;
    run(F + 4);

    // Randomized: data, blank_lz and occasional reset at random times
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: bcd_in = 16'h0000;
          1: bcd_in = {12'h000, 4'($urandom_range(0, 9))};
          2: bcd_in = 16'($urandom);
          default: bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
      end
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    run(F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
